shift42_frame_decoder: RTL

Downstream consumer of the 42-bit serial frame capture stage. Watches the serial shift-enable, and once a frame has been fully shifted in and is stable, it captures the parallel fields (marker `t`, `data[31:0]`, `rw`, `addr[7:0]`) into the system clock domain. It validates the frame and executes it against a local 32-bit register bank: a write updates a register; a read returns the register value both in parallel and serialized MSB-first on `sdo`. Sits between the serial capture latches and the trigger-logic configuration registers.

---
 rtl/shift42_frame_decoder_pkg.sv | 32 +++
 rtl/sync_edge_det.sv | 30 +++
 rtl/shift42_frame_decoder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shift42_frame_decoder_pkg.sv
// Shared definitions for the 42-bit serial frame decoder: field widths,
// FSM state encoding and the captured-frame layout.
package shift42_frame_decoder_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FRAME_W = 42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECODE,
        ST_WRITE,
        ST_READ,
        ST_SHIFT
    } state_t;

    typedef struct packed {
        logic              t;
        logic [DATA_W-1:0] data;
        logic              rw;
        logic [ADDR_W-1:0] addr;
    } frame_t;

    // Saturating 8-bit add; inc can be 2 when a reject and a drop coincide.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous enable, plus a history flop
// giving a single-cycle falling-edge pulse in the clk domain.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign sync_o = sync2_q;
    assign fall_o = hist_q & ~sync2_q;

endmodule

// File: rtl/shift42_frame_decoder.sv
// Captures a settled 42-bit serial frame into the clk domain and executes it
// against a local register bank; reads are also serialized MSB-first on sdo.
module shift42_frame_decoder
    import shift42_frame_decoder_pkg::*;
#(
    parameter int unsigned NREG      = 16,
    parameter logic [7:0]  ADDR_BASE = 8'h00,
    parameter int unsigned SETTLE    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_in,
    input  logic                 frm_t,
    input  logic                 frm_rw,
    input  logic [7:0]           frm_addr,
    input  logic [31:0]          frm_data,
    output logic [NREG*32-1:0]   regs_out,
    output logic                 wr_strobe,
    output logic [7:0]           wr_addr,
    output logic [31:0]          rd_data,
    output logic                 rd_valid,
    output logic                 sdo,
    output logic                 sdo_busy,
    output logic [7:0]           err_cnt,
    output logic [15:0]          frame_cnt
);

    localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic en_sync;
    logic eof;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (en_in),
        .sync_o  (en_sync),
        .fall_o  (eof)
    );

    state_t        state_q, state_d;
    logic [15:0]   settle_cnt_q, settle_cnt_d;
    frame_t        cap_q, cap_d;
    logic [31:0]   shift_q, shift_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic          sdo_q, sdo_d;
    logic          busy_q, busy_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    err_q, err_d;
    logic [15:0]   frame_q, frame_d;
    logic [31:0]   regs_q [NREG];

    logic [7:0]       idx;
    logic [IDX_W-1:0] sel;
    logic             idx_ok;
    logic             reg_we;
    logic [1:0]       err_inc;

    assign idx    = cap_q.addr - ADDR_BASE;
    assign sel    = idx[IDX_W-1:0];
    assign idx_ok = ({1'b0, idx} < 9'(NREG));

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        cap_d        = cap_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        sdo_d        = 1'b0;
        busy_d       = 1'b0;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        wr_strobe_d  = 1'b0;
        wr_addr_d    = wr_addr_q;
        frame_d      = frame_q;
        reg_we       = 1'b0;
        err_inc      = 2'd0;

        unique case (state_q)
            ST_IDLE: begin
                if (eof) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 16'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                if (en_sync) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == '0) begin
                    cap_d   = {frm_t, frm_data, frm_rw, frm_addr};
                    state_d = ST_DECODE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 16'd1;
                end
            end
            ST_DECODE: begin
                if (!cap_q.t || !idx_ok) begin
                    err_inc = 2'd1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = cap_q.rw ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                reg_we      = 1'b1;
                wr_addr_d   = idx;
                wr_strobe_d = 1'b1;
                frame_d     = frame_q + 16'd1;
                state_d     = ST_IDLE;
            end
            ST_READ: begin
                rd_data_d  = regs_q[sel];
                rd_valid_d = 1'b1;
                frame_d    = frame_q + 16'd1;
                shift_d    = regs_q[sel];
                bit_cnt_d  = 5'd31;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                sdo_d     = shift_q[31];
                busy_d    = 1'b1;
                shift_d   = {shift_q[30:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 5'd1;
                if (bit_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Any EOF outside IDLE (including on the edge returning to IDLE) is dropped.
        if (eof && state_q != ST_IDLE) begin
            err_inc = err_inc + 2'd1;
        end
        err_d = sat_add8(err_q, err_inc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            cap_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            sdo_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            err_q        <= '0;
            frame_q      <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            cap_q        <= cap_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            sdo_q        <= sdo_d;
            busy_q       <= busy_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            wr_strobe_q  <= wr_strobe_d;
            wr_addr_q    <= wr_addr_d;
            err_q        <= err_d;
            frame_q      <= frame_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[sel] <= cap_q.data;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regs_out
        assign regs_out[32*g +: 32] = regs_q[g];
    end

    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign sdo       = sdo_q;
    assign sdo_busy  = busy_q;
    assign err_cnt   = err_q;
    assign frame_cnt = frame_q;

endmodule
